// File: rtl/semis_cmp_pkg.sv
// Shared constants for the comparator bank: default geometry and the
// encoding of the per-bank output mode.
package semis_cmp_pkg;

  // Default bank geometry
  localparam int DEF_CHANNELS    = 4;
  localparam int DEF_FILT_BITS   = 3;
  localparam int DEF_SYNC_STAGES = 2;

  // Output mode carried on the sticky pin
  typedef enum logic {
    MODE_LEVEL  = 1'b0,  // out follows the filtered decision both ways
    MODE_STICKY = 1'b1   // out may rise but only clear/reset lowers it
  } cmp_mode_e;

endpackage : semis_cmp_pkg

// File: rtl/semis_cmp_channel.sv
// One comparator channel: synchronises the vip/vin pair, forms a decision
// only when the pair disagrees, debounces it through a consecutive-cycle
// counter and reports every change of out as a one-cycle pulse one cycle
// after the change.
module semis_cmp_channel
  import semis_cmp_pkg::*;
#(
  parameter int FILT_BITS   = DEF_FILT_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 vip,
  input  logic                 vin,
  input  logic [FILT_BITS-1:0] threshold,
  input  logic                 sticky,
  input  logic                 clear,
  output logic                 out,
  output logic                 edge_pulse
);

  // Synchroniser chains; bit 0 is the first stage
  logic [SYNC_STAGES-1:0] sync_p_reg;
  logic [SYNC_STAGES-1:0] sync_n_reg;

  // Filter state
  logic [FILT_BITS-1:0] count_reg;
  logic [FILT_BITS-1:0] count_next;
  logic                 out_reg;
  logic                 out_next;

  // Previous out value, used to detect changes for the pulse
  logic out_prev_reg;
  logic edge_pulse_reg;

  // Decision helpers
  logic                 sp;
  logic                 sn;
  logic                 decided;
  logic                 candidate;
  logic                 sticky_hold;
  logic [FILT_BITS-1:0] eff_thr;
  logic [FILT_BITS:0]   count_wide;
  logic [FILT_BITS-1:0] count_sat;
  cmp_mode_e            mode;

  assign sp        = sync_p_reg[SYNC_STAGES-1];
  assign sn        = sync_n_reg[SYNC_STAGES-1];
  assign decided   = sp ^ sn;
  assign candidate = sp;
  assign mode      = cmp_mode_e'(sticky);

  // A falling decision is suppressed while a sticky channel is high
  assign sticky_hold = (mode == MODE_STICKY) && out_reg;

  // A zero threshold behaves as one
  assign eff_thr = (threshold == '0) ? {{(FILT_BITS-1){1'b0}}, 1'b1} : threshold;

  // One extra bit so the "count+1 reaches threshold" test cannot wrap
  assign count_wide = {1'b0, count_reg} + {{FILT_BITS{1'b0}}, 1'b1};

  // Counter never wraps: it parks at all-ones
  assign count_sat = (count_reg == '1) ? count_reg : count_wide[FILT_BITS-1:0];

  // Shift the raw inputs through the synchroniser chains
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p_reg <= '0;
      sync_n_reg <= '0;
    end else begin
      sync_p_reg <= {sync_p_reg[SYNC_STAGES-2:0], vip};
      sync_n_reg <= {sync_n_reg[SYNC_STAGES-2:0], vin};
    end
  end

  // Next-state of the debounce filter; disable, then clear, then filtering
  always_comb begin
    count_next = count_reg;
    out_next   = out_reg;
    if (!en) begin
      // Disabled bank: out frozen, partial debounce discarded
      count_next = '0;
    end else if (clear) begin
      out_next   = 1'b0;
      count_next = '0;
    end else if (!decided) begin
      // Common mode carries no information: restart the run, hold out
      count_next = '0;
    end else if (candidate == out_reg) begin
      count_next = '0;
    end else if (sticky_hold) begin
      count_next = '0;
    end else if (count_wide >= {1'b0, eff_thr}) begin
      out_next   = candidate;
      count_next = '0;
    end else begin
      count_next = count_sat;
    end
  end

  // Filter state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
      out_reg   <= 1'b0;
    end else begin
      count_reg <= count_next;
      out_reg   <= out_next;
    end
  end

  // Change detector: pulse lands in the cycle after out moved
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_prev_reg   <= 1'b0;
      edge_pulse_reg <= 1'b0;
    end else begin
      out_prev_reg   <= out_reg;
      edge_pulse_reg <= out_reg ^ out_prev_reg;
    end
  end

  assign out        = out_reg;
  assign edge_pulse = edge_pulse_reg;

endmodule : semis_cmp_channel

// File: rtl/semis_comparator_bank.sv
// Bank of independent clocked comparator channels. Each channel owns its
// synchroniser and debounce filter; the bank only shares the control pins
// and registers the enable that drives the wrapper's uio_oe.
module semis_comparator_bank
  import semis_cmp_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int FILT_BITS   = DEF_FILT_BITS,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [CHANNELS-1:0]  vip,
  input  logic [CHANNELS-1:0]  vin,
  input  logic [FILT_BITS-1:0] threshold,
  input  logic                 sticky,
  input  logic                 clear,
  output logic [CHANNELS-1:0]  out,
  output logic [CHANNELS-1:0]  out_oe,
  output logic [CHANNELS-1:0]  edge_pulse
);

  logic [CHANNELS-1:0] out_oe_reg;

  // Output enable trails en by one cycle, replicated per channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_oe_reg <= '0;
    end else begin
      out_oe_reg <= {CHANNELS{en}};
    end
  end

  assign out_oe = out_oe_reg;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
      semis_cmp_channel #(
        .FILT_BITS  (FILT_BITS),
        .SYNC_STAGES(SYNC_STAGES)
      ) u_chan (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .vip       (vip[gi]),
        .vin       (vin[gi]),
        .threshold (threshold),
        .sticky    (sticky),
        .clear     (clear),
        .out       (out[gi]),
        .edge_pulse(edge_pulse[gi])
      );
    end
  endgenerate

endmodule : semis_comparator_bank

// File: tb/tb_semis_comparator_bank.sv
// Directed bench for semis_comparator_bank (4 channels, 3-bit filter,
// 2-stage synchroniser). A per-cycle vector table covers reset release,
// clear and glitch rejection; hand sequences cover the multi-cycle cases.
module tb_semis_comparator_bank;

  localparam int CH = 4;
  localparam int FB = 3;
  localparam int SS = 2;
  localparam int NV = 26;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [CH-1:0] vip;
  logic [CH-1:0] vin;
  logic [FB-1:0] threshold;
  logic          sticky;
  logic          clear;
  logic [CH-1:0] out;
  logic [CH-1:0] out_oe;
  logic [CH-1:0] edge_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [CH-1:0] vip;
    logic [CH-1:0] vin;
    logic [FB-1:0] thr;
    logic          clr;
    logic [CH-1:0] exp_out;
    logic [CH-1:0] exp_edge;
    logic [CH-1:0] exp_oe;
  } vec_t;

  vec_t vecs [NV];

  semis_comparator_bank #(
    .CHANNELS   (CH),
    .FILT_BITS  (FB),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .vip       (vip),
    .vin       (vin),
    .threshold (threshold),
    .sticky    (sticky),
    .clear     (clear),
    .out       (out),
    .out_oe    (out_oe),
    .edge_pulse(edge_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [CH-1:0] p, input logic [CH-1:0] n,
                         input logic [FB-1:0] t, input logic c, input logic [CH-1:0] eo,
                         input logic [CH-1:0] ee);
    vecs[i].vip      = p;
    vecs[i].vin      = n;
    vecs[i].thr      = t;
    vecs[i].clr      = c;
    vecs[i].exp_out  = eo;
    vecs[i].exp_edge = ee;
    vecs[i].exp_oe   = 4'hF;
  endtask

  initial begin
    // Reset release with all channels driven high: flip on the 5th edge
    for (int i = 0; i < 4; i++) set_vec(i, 4'hF, 4'h0, 3'd3, 1'b0, 4'h0, 4'h0);
    set_vec(4, 4'hF, 4'h0, 3'd3, 1'b0, 4'hF, 4'h0);
    set_vec(5, 4'hF, 4'h0, 3'd3, 1'b0, 4'hF, 4'hF);
    set_vec(6, 4'hF, 4'h0, 3'd3, 1'b0, 4'hF, 4'h0);
    // Clear everything while going common mode; pulse follows one cycle later
    set_vec(7, 4'h0, 4'h0, 3'd3, 1'b1, 4'h0, 4'h0);
    set_vec(8, 4'h0, 4'h0, 3'd4, 1'b0, 4'h0, 4'hF);
    set_vec(9, 4'h0, 4'h0, 3'd4, 1'b0, 4'h0, 4'h0);
    set_vec(10, 4'h0, 4'h0, 3'd4, 1'b0, 4'h0, 4'h0);
    // Three-cycle glitch on ch0 with threshold 4: rejected
    for (int i = 11; i < 14; i++) set_vec(i, 4'h1, 4'h0, 3'd4, 1'b0, 4'h0, 4'h0);
    for (int i = 14; i < 18; i++) set_vec(i, 4'h0, 4'h0, 3'd4, 1'b0, 4'h0, 4'h0);
    // Four-cycle pulse on ch0: accepted
    for (int i = 18; i < 22; i++) set_vec(i, 4'h1, 4'h0, 3'd4, 1'b0, 4'h0, 4'h0);
    set_vec(22, 4'h0, 4'h0, 3'd4, 1'b0, 4'h0, 4'h0);
    set_vec(23, 4'h0, 4'h0, 3'd4, 1'b0, 4'h1, 4'h0);
    set_vec(24, 4'h0, 4'h0, 3'd4, 1'b0, 4'h1, 4'h1);
    set_vec(25, 4'h0, 4'h0, 3'd4, 1'b0, 4'h1, 4'h0);

    rst_n = 1'b0; en = 1'b0; vip = 4'hF; vin = 4'h0;
    threshold = 3'd3; sticky = 1'b0; clear = 1'b0;
    repeat (3) tick();
    $display("reset held: out=%b out_oe=%b edge=%b", out, out_oe, edge_pulse);
    check("reset_out", out, 4'h0);
    check("reset_oe", out_oe, 4'h0);
    check("reset_edge", edge_pulse, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b1;

    for (int i = 0; i < NV; i++) begin
      vip = vecs[i].vip; vin = vecs[i].vin;
      threshold = vecs[i].thr; clear = vecs[i].clr;
      tick();
      $display("row %0d: vip=%b vin=%b thr=%0d clr=%b -> out=%b edge=%b oe=%b",
               i, vecs[i].vip, vecs[i].vin, vecs[i].thr, vecs[i].clr, out, edge_pulse, out_oe);
      check($sformatf("row%0d_out", i), out, vecs[i].exp_out);
      check($sformatf("row%0d_edge", i), edge_pulse, vecs[i].exp_edge);
      check($sformatf("row%0d_oe", i), out_oe, vecs[i].exp_oe);
    end
    clear = 1'b0;

    // Common mode: raise ch1, then hold vip=vin=1 for 20 cycles
    threshold = 3'd1; vip = 4'b0011; vin = 4'b0000;
    repeat (3) tick();
    check("cm_rise_out", out, 4'b0011);
    tick();
    check("cm_rise_edge", edge_pulse, 4'b0010);
    vin = 4'b0010;
    for (int i = 0; i < 20; i++) begin
      tick();
      $display("common mode cycle %0d: out=%b edge=%b", i, out, edge_pulse);
      check("cm_hold_out", out, 4'b0011);
      check("cm_hold_edge", edge_pulse, 4'b0000);
    end

    // Sticky: ch2 rises, reverse polarity cannot lower it, clear does
    sticky = 1'b1; vip = 4'b0111; vin = 4'b0000;
    repeat (3) tick();
    check("sticky_rise_out", out, 4'b0111);
    tick();
    check("sticky_rise_edge", edge_pulse, 4'b0100);
    vip = 4'b0011; vin = 4'b0100;
    for (int i = 0; i < 10; i++) begin
      tick();
      $display("sticky reverse cycle %0d: out=%b", i, out);
      check("sticky_hold_out", out, 4'b0111);
    end
    vip = 4'b0000; vin = 4'b0000;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    $display("sticky clear: out=%b", out);
    check("sticky_clear_out", out, 4'b0000);
    clear = 1'b0;
    tick();
    check("sticky_clear_edge", edge_pulse, 4'b0111);
    check("sticky_after_out", out, 4'b0000);
    sticky = 1'b0;

    // Threshold 0 acts as 1: one qualifying cycle on ch3 flips it
    threshold = 3'd0; vip = 4'b1000;
    tick();
    vip = 4'b0000;
    repeat (2) tick();
    $display("threshold0: out=%b", out);
    check("thr0_out", out, 4'b1000);
    tick();
    check("thr0_edge", edge_pulse, 4'b1000);
    check("thr0_hold", out, 4'b1000);

    // en drop with two qualifying cycles banked on ch3 (threshold 3)
    threshold = 3'd3; vip = 4'b0000; vin = 4'b1000;
    repeat (4) tick();
    en = 1'b0;
    tick();
    $display("en low: out=%b oe=%b", out, out_oe);
    check("en_off_oe", out_oe, 4'b0000);
    check("en_off_out", out, 4'b1000);
    tick();
    check("en_off_hold", out, 4'b1000);
    en = 1'b1;
    tick();
    check("en_on_oe", out_oe, 4'hF);
    check("en_on_c1", out, 4'b1000);
    tick();
    check("en_on_c2", out, 4'b1000);
    tick();
    $display("en resumed: out=%b", out);
    check("en_on_flip", out, 4'b0000);
    tick();
    check("en_on_edge", edge_pulse, 4'b1000);

    // Clear coinciding with a qualifying flip on ch0: clear wins
    threshold = 3'd1; vip = 4'b0001; vin = 4'b0000;
    repeat (2) tick();
    clear = 1'b1;
    tick();
    $display("clear vs flip: out=%b", out);
    check("clr_flip_out", out, 4'b0000);
    clear = 1'b0;
    tick();
    check("clr_then_flip", out, 4'b0001);
    check("clr_no_edge", edge_pulse, 4'b0000);
    tick();
    check("clr_then_edge", edge_pulse, 4'b0001);

    // Reset mid-debounce on ch1, then full latency after release
    threshold = 3'd3; vip = 4'b0011; vin = 4'b0000;
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: out=%b oe=%b edge=%b", out, out_oe, edge_pulse);
    check("arst_out", out, 4'b0000);
    check("arst_oe", out_oe, 4'b0000);
    check("arst_edge", edge_pulse, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("arst_rel_oe", out_oe, 4'hF);
    repeat (3) tick();
    check("arst_rel_c4", out, 4'b0000);
    tick();
    $display("after reset release: out=%b", out);
    check("arst_rel_flip", out, 4'b0011);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_semis_comparator_bank

// File: doc/semis_comparator_bank.md
# semis_comparator_bank

Multi-channel clocked digital comparator bank, the parametrised successor to our single-channel gate-level comparator experiment. Each channel synchronises a differential input pair (vip/vin), resolves a decision only when the pair disagrees, and debounces it through a programmable consecutive-cycle filter. The per-channel result can be level-following or sticky (latched until cleared). It sits inside the Tiny Tapeout top wrapper: pairs come from ui_in/uio_in, outputs go to uo_out, and out_oe drives uio_oe.

## Interface
- CHANNELS, 4: number of independent comparator channels (1..8).
- FILT_BITS, 3: width of the debounce threshold and per-channel counter.
- SYNC_STAGES, 2: synchroniser depth on vip/vin (≥2).

- clk  in  1  clock.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- en  in  1  bank enable; 0 freezes outputs and clears filters.
- vip  in  CHANNELS  positive input per channel (asynchronous).
- vin  in  CHANNELS  negative input per channel (asynchronous).
- threshold  in  FILT_BITS  consecutive qualifying cycles required to flip; 0 treated as 1.
- sticky  in  1  0 = level mode, 1 = sticky-high mode.
- clear  in  1  synchronous clear of out and counters (all channels).
- out  out  CHANNELS  filtered decision per channel.
- out_oe  out  CHANNELS  output enable per channel (replicated registered en).
- edge_pulse  out  CHANNELS  one-cycle pulse on any change of out[i].

## Operation
- Reset values: out=0, out_oe=0, edge_pulse=0, counters=0, synchroniser flops=0.
- Per channel, synchronised pair (sp, sn): if sp≠sn, candidate=sp; if sp==sn (common mode), no decision — counter cleared, out held.
- Filter: candidate≠out → counter+1; candidate==out → counter=0. When counter+1 reaches max(threshold,1), out←candidate, counter←0, edge_pulse=1 next cycle.
- Counter saturates; it never wraps (threshold ≤ 2^FILT_BITS−1 guarantees flip before saturation).
- Sticky mode: 0→1 transitions allowed; 1→0 suppressed (counter held at 0 while out=1). Only clear or reset returns out to 0.
- clear: out←0, counters←0; if out was 1, edge_pulse asserts for that channel. clear has priority over filter update.
- en=0: counters←0, out held, out_oe←0, no edge pulses. en 0→1: filtering resumes from held out.
- threshold/sticky changes take effect at the next edge; no counter reset.
- Channels are fully independent; no cross-channel arbitration.

## Timing
- Input stable before edge E0 → out updates at edge E(SYNC_STAGES+T−1), T=max(threshold,1); latency SYNC_STAGES+T cycles.
- edge_pulse is registered, high for exactly the cycle after out changes (aligned one cycle behind out).
- out_oe follows en with one cycle latency.
- Glitch shorter than T synchronised cycles produces no out change and no pulse.
- Reset mid-debounce: asynchronous clear of all state; first decision after release needs full SYNC_STAGES+T cycles.
- Simultaneous clear and qualifying flip: clear wins; out=0.

## Structure
- Package semis_cmp_pkg: default parameter constants (CHANNELS, FILT_BITS, SYNC_STAGES) and mode encoding constants (MODE_LEVEL=0, MODE_STICKY=1).
- Sub-module semis_cmp_channel: synchroniser, candidate logic, counter, out/edge registers for one channel; top generates CHANNELS instances and registers en→out_oe.
- No internal tristates; out_oe is exported for the wrapper's uio_oe.

## Test plan
- Reset: rst_n=0 with vip=1,vin=0 on all channels → out=0, out_oe=0, edge_pulse=0; release, en=1, threshold=3 → out[i]=1 at 5th edge (SYNC_STAGES=2), one edge_pulse.
- Glitch rejection: threshold=4, ch0 vip=1,vin=0 for 3 cycles then vip=vin=0 → out[0] stays 0, no pulse; 4-cycle pulse → out[0]=1.
- Common mode: out[1]=1, drive vip=vin=1 for 20 cycles → out[1] holds 1, counter stays 0.
- Sticky: sticky=1, ch2 goes 1, then vip=0,vin=1 for 10 cycles → out[2] stays 1; clear=1 one cycle → out[2]=0, edge_pulse[2]=1.
- threshold=0: single qualifying synchronised cycle flips out (behaves as threshold=1).
- en=0 mid-debounce (counter=2, threshold=3) → out_oe=0 next cycle, counter cleared; en=1 → flip needs full 3 qualifying cycles.
